// File: rtl/spi_mem_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_mem_sched                                                |
// | Description : Round-robin fetch/data scheduler driving the SPI memory      |
// |               engine strobes. Optional watchdog: SPI_SCHED_TIMEOUT_EN.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_mem_sched #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ack,
  output logic [7:0]  fetch_data,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [15:0] data_addr,
  input  logic [7:0]  data_wdata,
  output logic        data_ack,
  output logic [7:0]  data_rdata,
  output logic        err,
  output logic        busy,
  output logic        romo,
  output logic        ramo,
  output logic        rami,
  output logic [15:0] pc,
  output logic [15:0] mar,
  output logic [7:0]  databus,
  input  logic        executing,
  input  logic [7:0]  rom,
  input  logic [7:0]  ram
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BUSY  = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam int                 c_gap_w    = $clog2(GAP_CYCLES + 1);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);

  if (GAP_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("spi_mem_sched: GAP_CYCLES and TIMEOUT_CYCLES must be at least 2");
  end

  state_t             r_state;
  state_t             w_next;
  logic               r_last_data;
  logic               r_sel_data;
  logic               r_sel_we;
  logic [c_gap_w-1:0] r_gap_cnt;
  logic               w_grant;
  logic               w_grant_data;
  logic               w_timeout;
  logic               w_gap_en;
  logic               w_active;

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int                c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

  logic [c_to_w-1:0] r_to_cnt;
  logic              r_timed_out;

  // Fires only when the normal exit of START/BUSY is not taken this cycle.
  assign w_timeout = (r_to_cnt == c_to_last) &&
                     (((r_state == ST_START) && executing) ||
                      ((r_state == ST_BUSY) && !executing));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt    <= '0;
      r_timed_out <= 1'b0;
    end else begin
      if (r_state == ST_START || r_state == ST_BUSY)
        r_to_cnt <= r_to_cnt + 1'b1;
      else
        r_to_cnt <= '0;
      if (w_grant)
        r_timed_out <= 1'b0;
      else if (w_timeout)
        r_timed_out <= 1'b1;
    end
  end

  // An abandoned transfer must finish before the gap starts counting.
  assign w_gap_en = !r_timed_out || executing;
  assign err      = (r_state == ST_DONE) && r_timed_out;
`else
  assign w_timeout = 1'b0;
  assign w_gap_en  = 1'b1;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_grant      = 1'b0;
    w_grant_data = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fetch_req || data_req) begin
          w_grant      = 1'b1;
          w_grant_data = data_req && (!fetch_req || !r_last_data);
          w_next       = ST_START;
        end
      end
      ST_START: begin
        if (!executing)     w_next = ST_BUSY;
        else if (w_timeout) w_next = ST_DONE;
      end
      ST_BUSY: begin
        if (executing || w_timeout) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_GAP;
      ST_GAP: begin
        if (w_gap_en && (r_gap_cnt == c_gap_last)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_data <= 1'b1;
      r_sel_data  <= 1'b0;
      r_sel_we    <= 1'b0;
      r_gap_cnt   <= '0;
      pc          <= '0;
      mar         <= '0;
      databus     <= '0;
      fetch_data  <= '0;
      data_rdata  <= '0;
    end else begin
      if (w_grant) begin
        r_sel_data  <= w_grant_data;
        r_sel_we    <= data_we & w_grant_data;
        r_last_data <= w_grant_data;
        if (w_grant_data) begin
          mar     <= data_addr;
          databus <= data_wdata;
        end else begin
          pc <= fetch_addr;
        end
      end
      if (r_state == ST_BUSY && executing) begin
        if (!r_sel_data)    fetch_data <= rom;
        else if (!r_sel_we) data_rdata <= ram;
      end
      if (r_state != ST_GAP) r_gap_cnt <= '0;
      else if (w_gap_en)     r_gap_cnt <= r_gap_cnt + 1'b1;
    end
  end

  // Strobes decode from state so an asynchronous reset drops them at once.
  assign w_active  = (r_state == ST_START) || (r_state == ST_BUSY);
  assign romo      = w_active && !r_sel_data;
  assign ramo      = w_active && r_sel_data && !r_sel_we;
  assign rami      = w_active && r_sel_data && r_sel_we;
  assign fetch_ack = (r_state == ST_DONE) && !r_sel_data;
  assign data_ack  = (r_state == ST_DONE) && r_sel_data;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/spi_mem_sched.md
# spi_mem_sched

Scheduler in front of the SPI memory engine. Accepts instruction-fetch and data (load/store) requests from the CPU core, arbitrates them round-robin, and drives the engine's exclusive romo/ramo/rami strobes with held address/data. Each request completes with a one-cycle ack and, for reads, latched data. Sits between the CPU control unit and the SPI engine; both run on the same clock.

## Interface
- GAP_CYCLES, 2: cycles with all strobes low between transactions (min 2, so the engine re-arms its edge detect)
- TIMEOUT_CYCLES, 64: watchdog limit per transaction (only with SPI_SCHED_TIMEOUT_EN)

Ports:
- clk  in  1  system clock (same clock as the SPI engine's sclk)
- rst_n  in  1  asynchronous active-low reset
- fetch_req  in  1  fetch request (level, held until fetch_ack)
- fetch_addr  in  16  ROM address
- fetch_ack  out  1  one-cycle completion pulse
- fetch_data  out  8  last fetched byte
- data_req  in  1  data request (level, held until data_ack)
- data_we  in  1  1 = RAM write, 0 = RAM read
- data_addr  in  16  RAM address
- data_wdata  in  8  write byte
- data_ack  out  1  one-cycle completion pulse
- data_rdata  out  8  last RAM read byte
- err  out  1  pulses with an ack when the transaction timed out
- busy  out  1  high whenever state != IDLE
- romo, ramo, rami  out  1 each  engine strobes; at most one high
- pc, mar  out  16 each  engine addresses
- databus  out  8  engine write data
- executing  in  1  engine idle flag (low while transferring)
- rom, ram  in  8 each  engine read data

## Operation
- States: IDLE, START, BUSY, DONE, GAP.
- IDLE: sample fetch_req/data_req. If neither is set, stay. If one is set, grant it. If both are set, grant the requester not granted last (round-robin). On grant, latch address/wdata/we into pc or mar/databus, raise the selected strobe next cycle, and go to START.
- Strobe mapping: fetch -> romo; data read -> ramo; data write -> rami. Strobe, pc, mar and databus are held constant from START until GAP entry.
- START: wait for executing==0, then go to BUSY.
- BUSY: wait for executing==1. Then capture rom (fetch) into fetch_data or ram (data read) into data_rdata. A write captures nothing. Go to DONE.
- DONE: one cycle. Pulse the granted ack and drop all strobes. Go to GAP.
- GAP: count GAP_CYCLES cycles with strobes low, then go to IDLE. After a timeout, the count starts only once executing==1.
- last_grant updates on every grant. Reset value selects fetch first.
- Requests are sampled only in IDLE. Dropping req mid-transaction does not abort; ack still pulses. A req held after ack is treated as a new request.
- fetch_data and data_rdata hold their value until the next read of their own type completes.
- Reset (any state): strobes drop immediately and the FSM returns to IDLE. Any in-flight engine transfer is abandoned; the engine's own reset is responsible for it.

## Timing
- Reset values: all acks, err, busy, strobes = 0; pc, mar, databus, fetch_data, data_rdata = 0; state = IDLE.
- Grant to strobe high: 1 cycle. Strobe to executing low: engine-dependent, nominally 1 cycle.
- executing rising to ack: 1 cycle (BUSY sees it, DONE asserts ack). Read data is valid in the ack cycle.
- Back-to-back throughput: ack -> GAP_CYCLES -> IDLE -> grant. Same requester is re-granted no earlier than GAP_CYCLES+1 cycles after ack.
- Simultaneous fetch_req and data_req in IDLE: only one grant per IDLE cycle; the loser waits exactly one transaction.

## Configuration
- SPI_SCHED_TIMEOUT_EN defined:
  - A counter runs in START and BUSY.
  - When it reaches TIMEOUT_CYCLES, go to DONE with err=1 alongside the ack; read data registers are not updated.
  - GAP then waits for executing==1 before counting.
- Not defined:
  - No counter exists; err is tied to 0.
  - START/BUSY wait indefinitely.

## Test plan
Engine model: executing drops 1 cycle after a strobe rise and returns high 33 cycles later; it returns rom=0xA5 and ram=0x3C.
- Fetch from 0x1234 -> romo high and pc=0x1234 through BUSY, fetch_ack one cycle with fetch_data=0xA5, err=0.
- Write 0x77 to 0x8001 -> rami high, mar=0x8001, databus=0x77 held; data_ack pulses; data_rdata unchanged (0x00).
- fetch_req and data_req (read 0x0010) both held from reset -> fetch granted first, then data; ack order is fetch, then data. Strobes are low for ≥2 cycles between transactions, and ramo and romo are never high together.
- fetch_req held continuously for 3 transactions -> 3 fetch_acks, each separated by ≥ GAP_CYCLES+36 cycles; a data_req raised during the first transaction is served second.
- With SPI_SCHED_TIMEOUT_EN and executing stuck high -> after 64 cycles in START, data_ack and err pulse together, data_rdata stays at its old value, and the FSM returns to IDLE.
- rst_n asserted mid-BUSY -> strobes, busy and acks are 0 in the same cycle; a fresh request after release completes normally.
